// File: rtl/sprite_animator.sv
// Animated sprite renderer: per-frame animation sequencer plus a 3-stage pixel
// pipeline (address -> ROM read -> colour select) with mirroring and colour keying.
module sprite_animator #(
    parameter int SPR_W = 30,
    parameter int SPR_H = 64,
    parameter int NUM_ANIM = 4,
    parameter int FRAMES = 4,
    parameter int HOLD = 6,
    parameter logic [NUM_ANIM-1:0] LOOP_MASK = 4'b0011,
    parameter logic [11:0] KEY_RGB = 12'hD00,
    parameter int ADDR_W = 15,
    localparam int ANIM_W = (NUM_ANIM > 1) ? $clog2(NUM_ANIM) : 1,
    localparam int FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic                vga_clk,
    input  logic                Reset,
    input  logic                frame_start,
    input  logic [ANIM_W-1:0]   anim_sel,
    input  logic                facing_left,
    input  logic [9:0]          sprite_x,
    input  logic [9:0]          sprite_y,
    input  logic [9:0]          draw_x,
    input  logic [9:0]          draw_y,
    input  logic                blank,
    input  logic [11:0]         bg_rgb,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [11:0]         rom_rgb,
    output logic [7:0]          Red,
    output logic [7:0]          Green,
    output logic [7:0]          Blue,
    output logic [FRAME_W-1:0]  frame_idx,
    output logic                anim_done
);

    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(HOLD - 1);
    localparam logic [FRAME_W-1:0] FRAME_MAX = FRAME_W'(FRAMES - 1);
    localparam logic signed [11:0] HALF_W    = 12'(SPR_W / 2);
    localparam logic signed [11:0] HALF_H    = 12'(SPR_H / 2);
    localparam logic signed [11:0] SPR_W_S   = 12'(SPR_W);
    localparam logic signed [11:0] SPR_H_S   = 12'(SPR_H);
    localparam logic signed [11:0] SPR_W_M1  = 12'(SPR_W - 1);
    localparam logic [31:0] NF = 32'(FRAMES);
    localparam logic [31:0] NH = 32'(SPR_H);
    localparam logic [31:0] NW = 32'(SPR_W);

    typedef enum logic {PLAY, DONE} state_t;

    state_t              state_q, state_d;
    logic [ANIM_W-1:0]   cur_anim_q, cur_anim_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                mirror_q, mirror_d;
    logic [9:0]          sx_q, sx_d, sy_q, sy_d;

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            state_q    <= PLAY;
            cur_anim_q <= '0;
            frame_q    <= '0;
            hold_q     <= '0;
            mirror_q   <= 1'b0;
            sx_q       <= '0;
            sy_q       <= '0;
        end else begin
            state_q    <= state_d;
            cur_anim_q <= cur_anim_d;
            frame_q    <= frame_d;
            hold_q     <= hold_d;
            mirror_q   <= mirror_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_anim_d = cur_anim_q;
        frame_d    = frame_q;
        hold_d     = hold_q;
        mirror_d   = mirror_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        if (frame_start) begin
            mirror_d = facing_left;
            sx_d     = sprite_x;
            sy_d     = sprite_y;
            if (anim_sel != cur_anim_q) begin
                cur_anim_d = anim_sel;
                frame_d    = '0;
                hold_d     = '0;
                state_d    = PLAY;
            end else if (state_q == PLAY) begin
                if (hold_q < HOLD_MAX) begin
                    hold_d = hold_q + HOLD_W'(1);
                end else begin
                    hold_d = '0;
                    if (frame_q < FRAME_MAX)
                        frame_d = frame_q + FRAME_W'(1);
                    else if (LOOP_MASK[cur_anim_q])
                        frame_d = '0;
                    else
                        state_d = DONE;
                end
            end
        end
    end

    assign frame_idx = frame_q;
    assign anim_done = (state_q == DONE);

    // p0: sprite-relative coordinates, hit test and ROM address
    logic signed [11:0] col_p0, row_p0, mcol_p0;
    logic               hit_p0;
    logic [ADDR_W-1:0]  addr_p0;

    always_comb begin
        col_p0  = $signed({2'b00, draw_x}) - ($signed({2'b00, sx_q}) - HALF_W);
        row_p0  = $signed({2'b00, draw_y}) - ($signed({2'b00, sy_q}) - HALF_H);
        hit_p0  = !col_p0[11] && (col_p0 < SPR_W_S) && !row_p0[11] && (row_p0 < SPR_H_S);
        mcol_p0 = mirror_q ? (SPR_W_M1 - col_p0) : col_p0;
        addr_p0 = ADDR_W'(((32'(cur_anim_q) * NF + 32'(frame_q)) * NH
                           + 32'($unsigned(row_p0))) * NW + 32'($unsigned(mcol_p0)));
    end

    // p1: address registered; p2: ROM data arrives; p3: colour registered
    logic        hit_p1, vld_p1, hit_p2, vld_p2;
    logic [11:0] bg_p1, bg_p2, rgb_sel_p2, rgb_p3;

    always_comb begin
        rgb_sel_p2 = 12'h000;
        if (vld_p2)
            rgb_sel_p2 = (!hit_p2 || rom_rgb == KEY_RGB) ? bg_p2 : rom_rgb;
    end

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            rom_addr <= '0;
            hit_p1   <= 1'b0;
            vld_p1   <= 1'b0;
            hit_p2   <= 1'b0;
            vld_p2   <= 1'b0;
            rgb_p3   <= 12'h000;
        end else begin
            if (hit_p0)
                rom_addr <= addr_p0;
            hit_p1 <= hit_p0;
            vld_p1 <= blank;
            hit_p2 <= hit_p1;
            vld_p2 <= vld_p1;
            rgb_p3 <= rgb_sel_p2;
        end
    end

    always_ff @(posedge vga_clk) begin
        bg_p1 <= bg_rgb;
        bg_p2 <= bg_p1;
    end

    assign Red   = {rgb_p3[11:8], 4'h0};
    assign Green = {rgb_p3[7:4], 4'h0};
    assign Blue  = {rgb_p3[3:0], 4'h0};

endmodule

// File: tb/tb_sprite_animator.sv
// Directed self-checking bench for sprite_animator: reset, addressing, mirroring,
// keying, clipping, loop/one-shot sequencing and reset during an animation.
module tb_sprite_animator;

    logic        vga_clk = 1'b0;
    logic        Reset, frame_start, facing_left, blank;
    logic [1:0]  anim_sel;
    logic [9:0]  sprite_x, sprite_y, draw_x, draw_y;
    logic [11:0] bg_rgb, rom_rgb;
    logic [14:0] rom_addr;
    logic [7:0]  Red, Green, Blue;
    logic [1:0]  frame_idx;
    logic        anim_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 vga_clk = ~vga_clk;

    sprite_animator dut (
        .vga_clk(vga_clk), .Reset(Reset), .frame_start(frame_start),
        .anim_sel(anim_sel), .facing_left(facing_left),
        .sprite_x(sprite_x), .sprite_y(sprite_y),
        .draw_x(draw_x), .draw_y(draw_y), .blank(blank), .bg_rgb(bg_rgb),
        .rom_addr(rom_addr), .rom_rgb(rom_rgb),
        .Red(Red), .Green(Green), .Blue(Blue),
        .frame_idx(frame_idx), .anim_done(anim_done)
    );

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // One pixel through the pipe; ROM data is supplied one cycle after the address.
    task automatic pix(input string tag, input logic [9:0] dx, input logic [9:0] dy,
                       input logic bl, input logic [11:0] bg, input logic [11:0] rom,
                       input logic [23:0] exp_rgb, input logic [14:0] exp_addr);
        draw_x = dx; draw_y = dy; blank = bl; bg_rgb = bg;
        tick();
        chk({tag, "_addr"}, rom_addr, exp_addr);
        blank = 1'b0; draw_x = 10'd0; draw_y = 10'd0; bg_rgb = 12'h000;
        tick();
        chk({tag, "_early"}, {Red, Green, Blue}, 0);
        rom_rgb = rom;
        tick();
        chk({tag, "_rgb"}, {Red, Green, Blue}, exp_rgb);
        rom_rgb = 12'h000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; frame_start = 1'b0; anim_sel = 2'd0; facing_left = 1'b0;
        sprite_x = 10'd100; sprite_y = 10'd100; draw_x = 10'd0; draw_y = 10'd0;
        blank = 1'b0; bg_rgb = 12'h000; rom_rgb = 12'h000;
        repeat (3) tick();
        chk("rst_rgb", {Red, Green, Blue}, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_frame", frame_idx, 0);
        chk("rst_done", anim_done, 0);
        Reset = 1'b0;
        tick();

        // sprite centred at (100,100): top-left corner is (85,68)
        pulse();
        pix("key", 10'd85, 10'd68, 1'b1, 12'h123, 12'hD00, 24'h102030, 15'd0);
        pix("opaque", 10'd85, 10'd68, 1'b1, 12'h123, 12'h5A3, 24'h50A030, 15'd0);
        pix("row2", 10'd85, 10'd70, 1'b1, 12'h123, 12'h5A3, 24'h50A030, 15'd60);
        pix("leftmiss", 10'd84, 10'd68, 1'b1, 12'h123, 12'h5A3, 24'h102030, 15'd60);

        facing_left = 1'b1;
        pulse();
        pix("mir0", 10'd85, 10'd68, 1'b1, 12'h123, 12'h5A3, 24'h50A030, 15'd29);
        pix("mir2", 10'd85, 10'd70, 1'b1, 12'h123, 12'h5A3, 24'h50A030, 15'd89);

        facing_left = 1'b0; sprite_x = 10'd5;
        pulse();
        pix("clipl", 10'd0, 10'd68, 1'b1, 12'h456, 12'h5A3, 24'h50A030, 15'd10);
        pix("nowrap", 10'd1023, 10'd68, 1'b1, 12'h456, 12'h5A3, 24'h405060, 15'd10);
        pix("blank", 10'd0, 10'd68, 1'b0, 12'h456, 12'h5A3, 24'h000000, 15'd10);
        sprite_x = 10'd100;

        // looping animation 1
        anim_sel = 2'd1;
        pulse();
        chk("a1_sw_frame", frame_idx, 0);
        for (int i = 1; i <= 24; i++) begin
            pulse();
            chk($sformatf("a1_frame_%0d", i), frame_idx, 32'((i / 6) % 4));
            chk($sformatf("a1_done_%0d", i), anim_done, 0);
        end

        // one-shot animation 2, with a transient anim_sel change between pulses
        anim_sel = 2'd2;
        pulse();
        chk("a2_sw_frame", frame_idx, 0);
        anim_sel = 2'd0;
        repeat (3) tick();
        anim_sel = 2'd2;
        for (int i = 1; i <= 30; i++) begin
            pulse();
            chk($sformatf("a2_frame_%0d", i), frame_idx, 32'(((i / 6) > 3) ? 3 : (i / 6)));
            chk($sformatf("a2_done_%0d", i), anim_done, 32'(i >= 24));
        end
        anim_sel = 2'd0;
        pulse();
        chk("a0_sw_frame", frame_idx, 0);
        chk("a0_sw_done", anim_done, 0);

        // bring animation 0 to frame 2, hold count 4, then reset with a frame_start
        repeat (16) pulse();
        chk("pre_rst_frame", frame_idx, 2);
        draw_x = 10'd85; draw_y = 10'd70; blank = 1'b1; bg_rgb = 12'h789; rom_rgb = 12'h5A3;
        repeat (3) tick();
        chk("pre_rst_rgb", {Red, Green, Blue}, 24'h50A030);
        chk("pre_rst_addr", rom_addr, 3900);
        Reset = 1'b1; frame_start = 1'b1;
        tick();
        Reset = 1'b0; frame_start = 1'b0;
        chk("mid_rst_rgb", {Red, Green, Blue}, 0);
        chk("mid_rst_addr", rom_addr, 0);
        chk("mid_rst_frame", frame_idx, 0);
        chk("mid_rst_done", anim_done, 0);
        tick();
        chk("post_rst_rgb1", {Red, Green, Blue}, 0);
        tick();
        chk("post_rst_rgb2", {Red, Green, Blue}, 0);
        tick();
        // latched position is 0 after reset, so the pixel misses and shows background
        chk("post_rst_rgb3", {Red, Green, Blue}, 24'h708090);
        chk("post_rst_addr", rom_addr, 0);
        chk("post_rst_frame", frame_idx, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
